imem_port_arbiter: RTL and testbench

- Shares the single byte-wide, asynchronous-read instruction memory port between the fetch unit and a data-side reader. The data-side reader is a memory-stage load of 1–4 bytes, used for PC-relative constants and debug reads.
- Data reads are granted only at fetch instruction boundaries or while fetch is idle. During a data read, fetch is stalled.
- A fairness flag guarantees fetch completes one instruction between consecutive data reads.

---
 rtl/imem_port_arbiter_if.sv | 40 ++++
 rtl/imem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Signal bundle between the instruction-memory port arbiter, the fetch unit,
// the data-side reader and the byte-wide asynchronous instruction memory.
interface imem_port_arbiter_if;
    // Fetch side
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_boundary;
    logic        f_inst_done;
    logic        f_stall;

    // Data-side reader: d_req holds d_addr/d_len stable until a cycle with
    // d_ack=1, which consumes the request; d_done pulses once d_data is final.
    logic        d_req;
    logic [31:0] d_addr;
    logic [2:0]  d_len;
    logic        d_ack;
    logic        d_busy;
    logic        d_done;
    logic [31:0] d_data;

    // Memory port; read data is valid in the same cycle as the address
    logic [31:0] instmem_addr;
    logic [7:0]  instmem_dataout;

    modport slave (
        input  f_req, f_addr, f_boundary, f_inst_done,
        input  d_req, d_addr, d_len,
        input  instmem_dataout,
        output f_stall, d_ack, d_busy, d_done, d_data,
        output instmem_addr
    );

    modport master (
        output f_req, f_addr, f_boundary, f_inst_done,
        output d_req, d_addr, d_len,
        output instmem_dataout,
        input  f_stall, d_ack, d_busy, d_done, d_data,
        input  instmem_addr
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Time-shares the byte-wide instruction memory port between fetch and a 1..4
// byte data reader; data is granted only at instruction boundaries or idle fetch.
module imem_port_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    imem_port_arbiter_if.slave   bus,
    output logic                 o_dbg_state,
    output logic                 o_dbg_owed
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DXFER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_len;
    logic        r_owed;
    logic [31:0] r_data;
    logic        r_done;

    logic [2:0]  w_len_eff;
    logic        w_eligible;
    logic        w_grant;
    logic        w_last;
    logic        w_stall;
    logic [31:0] w_mem_addr;

    // Out-of-range lengths are clamped rather than rejected
    always_comb begin
        w_len_eff = bus.d_len;
        if (bus.d_len == 3'd0) begin
            w_len_eff = 3'd1;
        end else if (bus.d_len > 3'd4) begin
            w_len_eff = 3'd4;
        end
    end

    assign w_eligible = bus.f_boundary | ~bus.f_req;

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_last     = 1'b0;
        w_stall    = 1'b0;
        w_mem_addr = bus.f_addr;
        case (r_state)
            ST_FETCH: begin
                if (bus.d_req && w_eligible && !r_owed) begin
                    w_grant    = 1'b1;
                    w_stall    = 1'b1;
                    w_mem_addr = bus.d_addr;
                    if (w_len_eff == 3'd1) begin
                        w_last = 1'b1;
                    end else begin
                        w_next = ST_DXFER;
                    end
                end
            end
            ST_DXFER: begin
                w_stall    = 1'b1;
                w_mem_addr = r_addr + {30'd0, r_cnt};
                if ({1'b0, r_cnt} == (r_len - 3'd1)) begin
                    w_last = 1'b1;
                    w_next = ST_FETCH;
                end
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // A new grant clears the whole word so bytes beyond the length read as zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt  <= 2'd0;
            r_addr <= 32'd0;
            r_len  <= 3'd0;
            r_data <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_grant) begin
                r_addr <= bus.d_addr;
                r_len  <= w_len_eff;
                r_cnt  <= 2'd1;
                r_data <= {24'd0, bus.instmem_dataout};
            end else if (r_state == ST_DXFER) begin
                r_data[{r_cnt, 3'b000} +: 8] <= bus.instmem_dataout;
                r_cnt                        <= r_cnt + 2'd1;
            end
        end
    end

    // Setting on the last byte wins over clearing; fetch must then finish
    // an instruction (or go idle) before the next data grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_owed <= 1'b0;
        end else if (!FAIR) begin
            r_owed <= 1'b0;
        end else if (w_last) begin
            r_owed <= 1'b1;
        end else if ((r_state == ST_FETCH) && (bus.f_inst_done || !bus.f_req)) begin
            r_owed <= 1'b0;
        end
    end

    assign bus.f_stall      = w_stall;
    assign bus.d_busy       = w_stall;
    assign bus.d_ack        = w_grant;
    assign bus.instmem_addr = w_mem_addr;
    assign bus.d_done       = r_done;
    assign bus.d_data       = r_data;

    assign o_dbg_state = r_state;
    assign o_dbg_owed  = r_owed;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: one instance with fairness, one without,
// driven by the same stimulus and checked against a transaction-level model.
module tb_imem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_resetn;
    logic        t_f_req;
    logic [31:0] t_f_addr;
    logic        t_f_boundary;
    logic        t_f_inst_done;
    logic        t_d_req;
    logic [31:0] t_d_addr;
    logic [2:0]  t_d_len;

    imem_port_arbiter_if if_f ();
    imem_port_arbiter_if if_n ();

    logic dbg_state_f, dbg_owed_f, dbg_state_n, dbg_owed_n;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: begin
                t = a[7:0] + a[7:0] + a[7:0];
                return t ^ a[15:8] ^ a[31:24];
            end
        endcase
    endfunction

    assign if_f.f_req           = t_f_req;
    assign if_f.f_addr          = t_f_addr;
    assign if_f.f_boundary      = t_f_boundary;
    assign if_f.f_inst_done     = t_f_inst_done;
    assign if_f.d_req           = t_d_req;
    assign if_f.d_addr          = t_d_addr;
    assign if_f.d_len           = t_d_len;
    assign if_f.instmem_dataout = mem_byte(if_f.instmem_addr);

    assign if_n.f_req           = t_f_req;
    assign if_n.f_addr          = t_f_addr;
    assign if_n.f_boundary      = t_f_boundary;
    assign if_n.f_inst_done     = t_f_inst_done;
    assign if_n.d_req           = t_d_req;
    assign if_n.d_addr          = t_d_addr;
    assign if_n.d_len           = t_d_len;
    assign if_n.instmem_dataout = mem_byte(if_n.instmem_addr);

    imem_port_arbiter #(.FAIR(1'b1)) u_fair (
        .clk         (clk),
        .resetn      (t_resetn),
        .bus         (if_f),
        .o_dbg_state (dbg_state_f),
        .o_dbg_owed  (dbg_owed_f)
    );

    imem_port_arbiter #(.FAIR(1'b0)) u_nofair (
        .clk         (clk),
        .resetn      (t_resetn),
        .bus         (if_n),
        .o_dbg_state (dbg_state_n),
        .o_dbg_owed  (dbg_owed_n)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is a base address, a next index and a
    // number of bytes still to read; index 0 = FAIR=1 instance, 1 = FAIR=0.
    logic [31:0] m_base [2];
    logic [31:0] m_data [2];
    int          m_idx  [2];
    int          m_rem  [2];
    logic        m_owed [2];
    logic        m_done [2];

    logic        cap_ack   [2];
    logic        cap_stall [2];
    logic        cap_done  [2];
    logic [31:0] cap_addr  [2];
    logic [31:0] cap_data  [2];

    task automatic model_dut(input int k, input bit en,
                             input logic a_ack, input logic a_busy, input logic a_stall,
                             input logic [31:0] a_addr, input logic a_done,
                             input logic [31:0] a_data, input logic a_owed,
                             input logic a_state);
        logic        in_xfer, grant, last, e_busy;
        logic [31:0] e_addr;
        logic [7:0]  b;
        int          len;
        in_xfer = (m_rem[k] != 0);
        grant   = 1'b0;
        if (in_xfer) begin
            e_addr = m_base[k] + 32'(m_idx[k]);
            e_busy = 1'b1;
        end else begin
            grant  = t_d_req && (t_f_boundary || !t_f_req) && !m_owed[k];
            e_busy = grant;
            e_addr = grant ? t_d_addr : t_f_addr;
        end
        if (en) begin
            chk($sformatf("u%0d.d_ack", k), {31'd0, a_ack}, {31'd0, grant});
            chk($sformatf("u%0d.d_busy", k), {31'd0, a_busy}, {31'd0, e_busy});
            chk($sformatf("u%0d.f_stall", k), {31'd0, a_stall}, {31'd0, e_busy});
            chk($sformatf("u%0d.instmem_addr", k), a_addr, e_addr);
            chk($sformatf("u%0d.d_done", k), {31'd0, a_done}, {31'd0, m_done[k]});
            chk($sformatf("u%0d.d_data", k), a_data, m_data[k]);
            chk($sformatf("u%0d.owed", k), {31'd0, a_owed}, {31'd0, m_owed[k]});
            chk($sformatf("u%0d.state", k), {31'd0, a_state}, {31'd0, in_xfer});
        end
        b    = mem_byte(e_addr);
        last = 1'b0;
        if (grant) begin
            len       = (t_d_len == 3'd0) ? 1 : (t_d_len > 3'd4) ? 4 : int'(t_d_len);
            m_base[k] = t_d_addr;
            m_idx[k]  = 1;
            m_rem[k]  = len - 1;
            m_data[k] = {24'd0, b};
            last      = (len == 1);
        end else if (in_xfer) begin
            m_data[k] = m_data[k] | ({24'd0, b} << (8 * m_idx[k]));
            m_idx[k]  = m_idx[k] + 1;
            m_rem[k]  = m_rem[k] - 1;
            last      = (m_rem[k] == 0);
        end
        m_done[k] = last;
        if (k == 1) begin
            m_owed[k] = 1'b0;
        end else if (last) begin
            m_owed[k] = 1'b1;
        end else if (!in_xfer && (t_f_inst_done || !t_f_req)) begin
            m_owed[k] = 1'b0;
        end
        if (!t_resetn) begin
            m_rem[k]  = 0;
            m_idx[k]  = 0;
            m_owed[k] = 1'b0;
            m_done[k] = 1'b0;
            m_data[k] = 32'd0;
        end
    endtask

    task automatic step(input logic rn, input logic fr, input logic [31:0] fa,
                        input logic fb, input logic fd, input logic dr,
                        input logic [31:0] da, input logic [2:0] dl, input bit en);
        @(negedge clk);
        t_resetn      = rn;
        t_f_req       = fr;
        t_f_addr      = fa;
        t_f_boundary  = fb;
        t_f_inst_done = fd;
        t_d_req       = dr;
        t_d_addr      = da;
        t_d_len       = dl;
        #2;
        cap_ack[0]   = if_f.d_ack;   cap_ack[1]   = if_n.d_ack;
        cap_stall[0] = if_f.f_stall; cap_stall[1] = if_n.f_stall;
        cap_done[0]  = if_f.d_done;  cap_done[1]  = if_n.d_done;
        cap_addr[0]  = if_f.instmem_addr; cap_addr[1] = if_n.instmem_addr;
        cap_data[0]  = if_f.d_data;  cap_data[1]  = if_n.d_data;
        model_dut(0, en, if_f.d_ack, if_f.d_busy, if_f.f_stall, if_f.instmem_addr,
                  if_f.d_done, if_f.d_data, dbg_owed_f, dbg_state_f);
        model_dut(1, en, if_n.d_ack, if_n.d_busy, if_n.f_stall, if_n.instmem_addr,
                  if_n.d_done, if_n.d_data, dbg_owed_n, dbg_state_n);
    endtask

    typedef struct {
        logic        rn;
        logic        fr;
        logic [31:0] fa;
        logic        fb;
        logic        fd;
        logic        dr;
        logic [31:0] da;
        logic [2:0]  dl;
        logic        e_ack;
        logic        e_stall;
        logic [31:0] e_addr;
        logic        e_done;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [18];
    int   second_ack [2];
    int   n_acks [2];
    logic [31:0] exp_d;

    initial begin
        // idle read, clamp to 1 byte, wrap with clamp to 4, reset mid-transfer
        tbl[0]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'h40,       1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h100,      3'd4, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h101,      1'b0, 32'h11};
        tbl[3]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h102,      1'b0, 32'h2211};
        tbl[4]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h103,      1'b0, 32'h332211};
        tbl[5]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'h40,       1'b1, 32'h44332211};
        tbl[6]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h200,      3'd0, 1'b1, 1'b1, 32'h200,      1'b0, 32'h44332211};
        tbl[7]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'h40,       1'b1, 32'h02};
        tbl[8]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 3'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h02};
        tbl[9]  = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hFA};
        tbl[10] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h0,        1'b0, 32'hFDFA};
        tbl[11] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h1,        1'b0, 32'h00FDFA};
        tbl[12] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'h40,       1'b1, 32'h0300FDFA};
        tbl[13] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h100,      3'd4, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0300FDFA};
        tbl[14] = '{1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'h101,      1'b0, 32'h11};
        tbl[15] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'h40,       1'b0, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h102,      3'd1, 1'b1, 1'b1, 32'h102,      1'b0, 32'h0};
        tbl[17] = '{1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'h40,       1'b1, 32'h33};

        // clock/reset: registers are unknown before the first reset edge
        step(1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rn, tbl[i].fr, tbl[i].fa, tbl[i].fb, tbl[i].fd,
                 tbl[i].dr, tbl[i].da, tbl[i].dl, 1'b1);
            chk($sformatf("tbl%0d.d_ack", i), {31'd0, cap_ack[0]}, {31'd0, tbl[i].e_ack});
            chk($sformatf("tbl%0d.f_stall", i), {31'd0, cap_stall[0]}, {31'd0, tbl[i].e_stall});
            chk($sformatf("tbl%0d.instmem_addr", i), cap_addr[0], tbl[i].e_addr);
            chk($sformatf("tbl%0d.d_done", i), {31'd0, cap_done[0]}, {31'd0, tbl[i].e_done});
            chk($sformatf("tbl%0d.d_data", i), cap_data[0], tbl[i].e_data);
        end

        // boundary wait: fetch mid-instruction holds off the data grant
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b1, 32'h300, 3'd2, 1'b1);
            chk($sformatf("bwait%0d.no_ack", i), {31'd0, cap_ack[0]}, 32'd0);
        end
        step(1'b1, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b1, 32'h300, 3'd2, 1'b1);
        chk("bwait.ack", {31'd0, cap_ack[0]}, 32'd1);
        chk("bwait.stall0", {31'd0, cap_stall[0]}, 32'd1);
        step(1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
        chk("bwait.stall1", {31'd0, cap_stall[0]}, 32'd1);
        step(1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
        chk("bwait.stall2", {31'd0, cap_stall[0]}, 32'd0);
        chk("bwait.done", {31'd0, cap_done[0]}, 32'd1);
        chk("bwait.upper", {16'd0, cap_data[0][31:16]}, 32'd0);
        exp_d = {16'd0, mem_byte(32'h301), mem_byte(32'h300)};
        chk("bwait.data", cap_data[0], exp_d);

        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
        end

        // fairness: d_req held, 2-byte instructions (boundary on even cycles)
        second_ack[0] = -1; second_ack[1] = -1;
        n_acks[0] = 0; n_acks[1] = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 32'h2000 + 32'(c), (c % 2) == 0, (c % 2) == 1,
                 1'b1, 32'h400, 3'd2, 1'b1);
            for (int k = 0; k < 2; k++) begin
                if (cap_ack[k]) begin
                    if (n_acks[k] == 1) second_ack[k] = c;
                    n_acks[k]++;
                end
            end
        end
        chk("fair.second_ack_cycle", 32'(second_ack[0]), 32'd4);
        chk("nofair.second_ack_cycle", 32'(second_ack[1]), 32'd2);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
        end

        // request inputs change after the ack; latched values must win
        step(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b1, 32'h500, 3'd3, 1'b1);
        chk("chg.ack", {31'd0, cap_ack[0]}, 32'd1);
        chk("chg.addr0", cap_addr[0], 32'h500);
        step(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h900, 3'd1, 1'b1);
        chk("chg.addr1", cap_addr[0], 32'h501);
        step(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h900, 3'd1, 1'b1);
        chk("chg.addr2", cap_addr[0], 32'h502);
        chk("chg.not_done", {31'd0, cap_done[0]}, 32'd0);
        step(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h900, 3'd1, 1'b1);
        chk("chg.done", {31'd0, cap_done[0]}, 32'd1);
        chk("chg.stall", {31'd0, cap_stall[0]}, 32'd0);
        exp_d = {8'd0, mem_byte(32'h502), mem_byte(32'h501), mem_byte(32'h500)};
        chk("chg.data", cap_data[0], exp_d);

        // randomized traffic against the model, both instances
        for (int i = 0; i < 800; i++) begin
            logic [31:0] da;
            da = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                             : $urandom;
            step($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0, da, 3'($urandom_range(0, 7)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
